// File: rtl/forth_stack_engine_if.sv
// Op/status bundle for forth_stack_engine: the bench or core drives ops, the
// engine reports its cached stack view and sticky error flags.
interface forth_stack_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = $clog2(DEPTH + 3);

  // op_valid qualifies op/din for exactly the cycle it is high; there is no
  // ready (every op is sampled), and op_done reports acceptance one cycle later.
  logic                  op_valid;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] din;
  logic                  clear_err;
  logic [DATA_WIDTH-1:0] tos;
  logic [DATA_WIDTH-1:0] nos;
  logic [CNT_W-1:0]      depth;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;
  logic                  op_done;

  modport master (
    output op_valid, op, din, clear_err,
    input  tos, nos, depth, empty, full, overflow, underflow, op_done
  );

  modport slave (
    input  op_valid, op, din, clear_err,
    output tos, nos, depth, empty, full, overflow, underflow, op_done
  );
endinterface

// File: rtl/forth_stack_engine.sv
// Forth data stack: TOS/NOS cached in registers, deeper cells spilled to a
// DEPTH-entry array; every legal op completes in a single cycle.
module forth_stack_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input logic                read_clock,
  input logic                reset,
  forth_stack_engine_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 3);
  localparam int SP_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH + 2);
  localparam logic [CNT_W-1:0] C1 = CNT_W'(1);
  localparam logic [CNT_W-1:0] C2 = CNT_W'(2);
  localparam logic [CNT_W-1:0] C3 = CNT_W'(3);

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_DROP    = 3'd2,
    OP_DUP     = 3'd3,
    OP_SWAP    = 3'd4,
    OP_OVER    = 3'd5,
    OP_REPLACE = 3'd6,
    OP_BINARY  = 3'd7
  } op_e;

  logic [DATA_WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
  logic [CNT_W-1:0]      depth_q, depth_d;
  logic [SP_W-1:0]       sp_q, sp_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] spill_q [DEPTH];

  op_e                   op_cur;
  logic                  has1, has2, has3, is_full;
  logic                  under, over, accept, spill_we;
  logic [SP_W-1:0]       push_idx, pop_sp;
  logic [DATA_WIDTH-1:0] pop_nos;

  assign op_cur = op_e'(bus.op);

  always_comb begin
    has1    = depth_q >= C1;
    has2    = depth_q >= C2;
    has3    = depth_q >= C3;
    is_full = depth_q == FULL_CNT;
    // sp_q names the topmost occupied spill cell and rests at 0 when none is,
    // so it never leaves 0..DEPTH-1; cells vacated with nothing below read 0.
    push_idx = has3 ? sp_q + SP_W'(1) : '0;
    pop_nos  = has3 ? spill_q[sp_q] : '0;
    pop_sp   = (depth_q > C3) ? sp_q - SP_W'(1) : '0;

    under = 1'b0;
    over  = 1'b0;
    case (op_cur)
      OP_PUSH:    over  = is_full;
      OP_DROP:    under = !has1;
      OP_DUP:     begin under = !has1; over = has1 && is_full; end
      OP_SWAP:    under = !has2;
      OP_OVER:    begin under = !has2; over = has2 && is_full; end
      OP_REPLACE: under = !has1;
      OP_BINARY:  under = !has2;
      default:    ;
    endcase
    accept = bus.op_valid && !under && !over;

    tos_d    = tos_q;
    nos_d    = nos_q;
    depth_d  = depth_q;
    sp_d     = sp_q;
    spill_we = 1'b0;
    if (accept) begin
      case (op_cur)
        OP_PUSH: begin
          spill_we = has2;
          sp_d     = push_idx;
          nos_d    = tos_q;
          tos_d    = bus.din;
          depth_d  = depth_q + C1;
        end
        OP_DROP: begin
          tos_d   = nos_q;
          nos_d   = pop_nos;
          sp_d    = pop_sp;
          depth_d = depth_q - C1;
        end
        OP_DUP: begin
          spill_we = has2;
          sp_d     = push_idx;
          nos_d    = tos_q;
          depth_d  = depth_q + C1;
        end
        OP_SWAP: begin
          tos_d = nos_q;
          nos_d = tos_q;
        end
        OP_OVER: begin
          spill_we = has2;
          sp_d     = push_idx;
          nos_d    = tos_q;
          tos_d    = nos_q;
          depth_d  = depth_q + C1;
        end
        OP_REPLACE: tos_d = bus.din;
        OP_BINARY: begin
          tos_d   = bus.din;
          nos_d   = pop_nos;
          sp_d    = pop_sp;
          depth_d = depth_q - C1;
        end
        default: ;
      endcase
    end

    // A fresh error outranks a simultaneous clear.
    ovf_d  = (bus.op_valid && over)  ? 1'b1 : (bus.clear_err ? 1'b0 : ovf_q);
    unf_d  = (bus.op_valid && under) ? 1'b1 : (bus.clear_err ? 1'b0 : unf_q);
    done_d = accept;
  end

  always_ff @(posedge read_clock) begin
    if (reset) begin
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge read_clock) begin
    if (spill_we && !reset) spill_q[push_idx] <= nos_q;
  end

  assign bus.tos       = tos_q;
  assign bus.nos       = nos_q;
  assign bus.depth     = depth_q;
  assign bus.empty     = depth_q == '0;
  assign bus.full      = depth_q == FULL_CNT;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.op_done   = done_q;
endmodule

// File: doc/forth_stack_engine.md
FORTH_STACK_ENGINE -- requirements
Module: forth_stack_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the width of each stack cell.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of spill-RAM cells below NOS; legal values are DEPTH >= 2.
REQ-003 SHALL have read_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have op_valid, input, 1 bit: the op is executed this cycle.
REQ-006 SHALL have op, input, 3 bits, encoded as:
- 0 NOP
- 1 PUSH
- 2 DROP
- 3 DUP
- 4 SWAP
- 5 OVER
- 6 REPLACE
- 7 BINARY
REQ-007 SHALL have din, input, DATA_WIDTH bits: literal or ALU result for PUSH, REPLACE and BINARY.
REQ-008 SHALL have clear_err, input, 1 bit: clears the sticky error flags.
REQ-009 SHALL have tos, output, DATA_WIDTH bits: the top-of-stack register.
REQ-010 SHALL have nos, output, DATA_WIDTH bits: the next-of-stack register.
REQ-011 SHALL have depth, output, $clog2(DEPTH+3) bits: the logical cell count, 0..DEPTH+2.
REQ-012 SHALL have empty and full, outputs, 1 bit each: empty means depth==0; full means depth==DEPTH+2.
REQ-013 SHALL have overflow and underflow, outputs, 1 bit each: sticky error flags.
REQ-014 SHALL have op_done, output, 1 bit: a registered pulse, one cycle after an accepted legal op.

Function
REQ-015 SHALL be organised as cached TOS/NOS registers over a DEPTH-entry spill array with a spill pointer; capacity is DEPTH+2.
REQ-016 SHALL complete each legal op in one cycle; tos, nos and depth SHALL be updated on the edge that samples op_valid=1.
REQ-017 SHALL perform PUSH as: nos->spill, tos->nos, din->tos, depth+1; legal only if !full.
REQ-018 SHALL perform DROP as: nos->tos, spill top->nos, depth-1; legal only if depth>=1.
REQ-019 SHALL perform DUP as: nos->spill, tos->nos, tos unchanged, depth+1; legal only if depth>=1 and !full.
REQ-020 SHALL perform SWAP as an exchange of tos and nos with depth unchanged; legal only if depth>=2.
REQ-021 SHALL perform OVER as: nos->spill, tos->nos, old nos->tos, depth+1; legal only if depth>=2 and !full.
REQ-022 SHALL perform REPLACE as din->tos, with everything else unchanged; legal only if depth>=1.
REQ-023 SHALL perform BINARY as: din->tos, spill top->nos, depth-1; legal only if depth>=2.
REQ-024 SHALL load 0 into any register or cell vacated when no valid cell lies below it, so invalid positions always read 0. Examples: nos after DROP at depth<=2; tos after DROP at depth 1.
REQ-025 SHALL treat an illegal op that would exceed capacity as an overflow: set overflow, change no state, give no op_done.
REQ-026 SHALL treat an illegal op with insufficient depth as an underflow: set underflow, change no state, give no op_done.
REQ-027 SHALL ignore op while op_valid=0, and SHALL treat NOP as legal (op_done pulses, no state change).
REQ-028 SHALL clear both flags on clear_err=1; if an error occurs in the same cycle as clear_err, the error wins and the flag reads 1.
REQ-029 SHALL keep the spill pointer strictly within 0..DEPTH-1 with no wrap-around; full and empty SHALL be derived from depth only.
REQ-030 SHALL leave spill-array contents undefined after reset; REQ-024 guarantees they are never observable.

Reset
REQ-031 SHALL, on reset=1 at a rising edge, set tos=0, nos=0, depth=0, spill pointer=0, overflow=0, underflow=0, op_done=0.
REQ-032 SHALL give reset priority over op_valid and clear_err in the same cycle; an op in flight is discarded.

Verification
REQ-033 SHALL be verified, with DATA_WIDTH=16 and DEPTH=4, by PUSH 0x0001..0x0006 -> depth=6, full=1, tos=0x0006, nos=0x0005; then a 7th PUSH 0x0007 -> overflow=1, no op_done, tos still 0x0006.
REQ-034 SHALL be verified by DROP x6 from the REQ-033 state -> tos sequence 5,4,3,2,1,0; empty=1; nos=0 once depth<=1; a 7th DROP -> underflow=1, depth stays 0.
REQ-035 SHALL be verified by PUSH 0x00AA, PUSH 0x00BB, then OVER -> tos=0x00AA, nos=0x00BB, depth=3; then SWAP -> tos=0x00BB, nos=0x00AA.
REQ-036 SHALL be verified by PUSH 3, PUSH 4, then BINARY with din=7 -> tos=7, nos=0, depth=1; then BINARY -> underflow=1, state unchanged.
REQ-037 SHALL be verified by raising underflow, then driving clear_err and an illegal DROP in the same cycle -> underflow stays 1; clear_err alone next cycle -> 0.
REQ-038 SHALL be verified by asserting reset together with a valid PUSH at depth 3 -> next cycle depth=0, tos=0, nos=0, op_done=0, flags 0.
